// File: rtl/wav_stream_player_if.sv
// Byte-stream handshake into the WAV player: the producer drives valid/data,
// the player answers with ready; a byte moves on a clock edge with valid && ready.
interface wav_stream_player_if;
  logic       byte_val_i;
  logic [7:0] byte_data_i;
  logic       byte_rdy_o;

  modport master (
    output byte_val_i,
    output byte_data_i,
    input  byte_rdy_o
  );

  modport slave (
    input  byte_val_i,
    input  byte_data_i,
    output byte_rdy_o
  );
endinterface

// File: rtl/wav_stream_player.sv
// Parses a canonical 44-byte PCM WAV header from a byte stream, buffers the
// data-chunk bytes in a small FIFO and replays them as 8-bit mono samples.
module wav_stream_player #(
  parameter int          CLK_DIV    = 259,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SILENCE    = 8'h80
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wav_stream_player_if.slave  bus,
  output logic                sample_val_o,
  output logic [7:0]          sample_data_o,
  output logic [31:0]         sample_rate_o,
  output logic [31:0]         data_size_o,
  output logic                hdr_ok_o,
  output logic                hdr_err_o,
  output logic [15:0]         underrun_cnt_o,
  output logic                done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     rate_sh_q, rate_sh_d;
  logic [23:0]     size_sh_q, size_sh_d;
  logic [31:0]     rate_q, rate_d;
  logic [31:0]     size_q, size_d;
  logic [31:0]     rem_q, rem_d;
  logic            hdr_ok_q, hdr_ok_d;
  logic            byte_rdy_q, byte_rdy_d;
  logic            sample_val_q, sample_val_d;
  logic [7:0]      sample_data_q, sample_data_d;
  logic [15:0]     underrun_q, underrun_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            tick;
  logic            xfer;
  logic            push;
  logic            pop;
  logic            playing;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_full_nxt;
  logic [31:0]     size_full;

  // Fixed header bytes; positions not listed (sizes, rate, byte rate, align) pass.
  function automatic logic hdr_byte_ok(input logic [5:0] idx, input logic [7:0] b);
    logic ok;
    case (idx)
      6'd0:  ok = (b == 8'h52);
      6'd1:  ok = (b == 8'h49);
      6'd2:  ok = (b == 8'h46);
      6'd3:  ok = (b == 8'h46);
      6'd8:  ok = (b == 8'h57);
      6'd9:  ok = (b == 8'h41);
      6'd10: ok = (b == 8'h56);
      6'd11: ok = (b == 8'h45);
      6'd12: ok = (b == 8'h66);
      6'd13: ok = (b == 8'h6d);
      6'd14: ok = (b == 8'h74);
      6'd15: ok = (b == 8'h20);
      6'd16: ok = (b == 8'd16);
      6'd17: ok = (b == 8'd0);
      6'd18: ok = (b == 8'd0);
      6'd19: ok = (b == 8'd0);
      6'd20: ok = (b == 8'd1);
      6'd21: ok = (b == 8'd0);
      6'd22: ok = (b == 8'd1);
      6'd23: ok = (b == 8'd0);
      6'd34: ok = (b == 8'd8);
      6'd35: ok = (b == 8'd0);
      6'd36: ok = (b == 8'h64);
      6'd37: ok = (b == 8'h61);
      6'd38: ok = (b == 8'h74);
      6'd39: ok = (b == 8'h61);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign tick          = (div_q == DW'(CLK_DIV));
  assign xfer          = bus.byte_val_i && byte_rdy_q;
  assign playing       = (state_q == S_DATA) || (state_q == S_DONE);
  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push          = xfer && (state_q == S_DATA) && !fifo_full;
  assign pop           = tick && playing && !fifo_empty;
  assign size_full     = {bus.byte_data_i, size_sh_q};
  assign fifo_full_nxt = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                         (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Header parse and stream control
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rate_sh_d = rate_sh_q;
    size_sh_d = size_sh_q;
    rate_d    = rate_q;
    size_d    = size_q;
    rem_d     = rem_q;
    hdr_ok_d  = hdr_ok_q;
    case (state_q)
      S_HDR: begin
        if (xfer) begin
          idx_d = idx_q + 6'd1;
          if (idx_q >= 6'd24 && idx_q <= 6'd27) begin
            rate_sh_d[{idx_q[1:0], 3'b000} +: 8] = bus.byte_data_i;
          end
          if (idx_q >= 6'd40 && idx_q <= 6'd42) begin
            size_sh_d[{idx_q[1:0], 3'b000} +: 8] = bus.byte_data_i;
          end
          if (!hdr_byte_ok(idx_q, bus.byte_data_i)) begin
            state_d = S_ERR;
          end else if (idx_q == 6'd43) begin
            rate_d   = rate_sh_q;
            size_d   = size_full;
            rem_d    = size_full;
            hdr_ok_d = 1'b1;
            state_d  = (size_full == 32'd0) ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (push) begin
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // FIFO pointers and registered ready, derived from next-cycle state so
  // ready stays low while full even when a pop happens the same cycle
  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW + 1)'(pop);
    byte_rdy_d = (state_d == S_HDR) || ((state_d == S_DATA) && !fifo_full_nxt);
  end

  // Playback on the sample tick
  always_comb begin
    sample_val_d  = 1'b0;
    sample_data_d = sample_data_q;
    underrun_d    = underrun_q;
    if (tick && playing) begin
      if (!fifo_empty) begin
        sample_val_d  = 1'b1;
        sample_data_d = mem_q[rd_ptr_q[AW-1:0]];
      end else begin
        sample_data_d = SILENCE;
        if ((state_q == S_DATA) && (underrun_q != 16'hFFFF)) begin
          underrun_d = underrun_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_HDR;
      div_q         <= '0;
      idx_q         <= '0;
      rate_q        <= '0;
      size_q        <= '0;
      rem_q         <= '0;
      hdr_ok_q      <= 1'b0;
      byte_rdy_q    <= 1'b0;
      sample_val_q  <= 1'b0;
      sample_data_q <= SILENCE;
      underrun_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      rate_q        <= rate_d;
      size_q        <= size_d;
      rem_q         <= rem_d;
      hdr_ok_q      <= hdr_ok_d;
      byte_rdy_q    <= byte_rdy_d;
      sample_val_q  <= sample_val_d;
      sample_data_q <= sample_data_d;
      underrun_q    <= underrun_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Shadow fields and sample storage are fully rewritten before use
  always_ff @(posedge clk_i) begin
    rate_sh_q <= rate_sh_d;
    size_sh_q <= size_sh_d;
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.byte_data_i;
    end
  end

  assign bus.byte_rdy_o  = byte_rdy_q;
  assign sample_val_o    = sample_val_q;
  assign sample_data_o   = sample_data_q;
  assign sample_rate_o   = rate_q;
  assign data_size_o     = size_q;
  assign hdr_ok_o        = hdr_ok_q;
  assign hdr_err_o       = (state_q == S_ERR);
  assign underrun_cnt_o  = underrun_q;
  assign done_o          = (state_q == S_DONE) && fifo_empty;

endmodule
